// File: rtl/wb_input_debounce_pkg.sv
// Shared constants for the input debounce peripheral: register word offsets,
// the 50 MHz debounce default and the byte-lane mask helper.
package wb_input_debounce_pkg;

  localparam int unsigned REG_STATE   = 0;
  localparam int unsigned REG_EVENT   = 1;
  localparam int unsigned REG_RISE_EN = 2;
  localparam int unsigned REG_FALL_EN = 3;
  localparam int unsigned REG_EVCNT   = 4;

  // 10 ms of stability at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_input_debounce_if.sv
// Wishbone slave bus bundle for the input debounce peripheral.
interface wb_input_debounce_if #(
  parameter int unsigned DEV_ADDR_BITS = 8
);
  logic                     wbs_cs_i;
  logic [DEV_ADDR_BITS-3:0] wbs_addr_i;
  logic [3:0]               wbs_sel_i;
  logic [31:0]              wbs_data_i;
  logic                     wbs_we_i;
  logic [31:0]              wbs_data_o;
  logic                     wbs_ack_o;

  modport master (
    output wbs_cs_i, wbs_addr_i, wbs_sel_i, wbs_data_i, wbs_we_i,
    input  wbs_data_o, wbs_ack_o
  );

  modport slave (
    input  wbs_cs_i, wbs_addr_i, wbs_sel_i, wbs_data_i, wbs_we_i,
    output wbs_data_o, wbs_ack_o
  );
endinterface

// File: rtl/wb_input_debounce_debounce_bit.sv
// One input bit: two-flop synchroniser, stability counter and clean flop,
// with single-cycle rise/fall strobes coincident with the clean toggle.
module wb_input_debounce_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_BITS        = 20
) (
  input  logic wbs_clk_i,
  input  logic rst,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                clean_q, clean_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                toggle_s;

  // Next-state: any return to agreement discards the partial count
  always_comb begin
    sync1_d  = raw_i;
    sync2_d  = sync1_q;
    clean_d  = clean_q;
    cnt_d    = cnt_q;
    toggle_s = 1'b0;
    if (sync2_q == clean_q) begin
      cnt_d = {CNT_BITS{1'b0}};
    end else if (cnt_q == CNT_BITS'(DEBOUNCE_CYCLES - 1)) begin
      toggle_s = 1'b1;
      clean_d  = ~clean_q;
      cnt_d    = {CNT_BITS{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  // State registers
  always_ff @(posedge wbs_clk_i) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= {CNT_BITS{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = toggle_s & ~clean_q;
  assign fall_o  = toggle_s & clean_q;

endmodule

// File: rtl/wb_input_debounce.sv
// Debounced switch/button inputs with Wishbone-visible edge events and a
// level interrupt. Define INPUT_EVENT_COUNT_EN to add the EVCNT counter.
module wb_input_debounce
  import wb_input_debounce_pkg::*;
#(
  parameter int unsigned DEV_ADDR_BITS   = 8,
  parameter int unsigned IN_WIDTH        = 13,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_BITS        = 20
) (
  input  logic                wbs_clk_i,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] raw_in,
  output logic [IN_WIDTH-1:0] clean_out,
  wb_input_debounce_if.slave  wb,
  output logic                interrupt
);

  localparam int unsigned AW = DEV_ADDR_BITS - 2;

  logic [IN_WIDTH-1:0] clean_s, rise_s, fall_s;
  logic [AW-1:0]       addr_s;
  logic                access_s, wr_s;
  logic [31:0]         set_s, lane_s, rdata_s;

  logic [31:0] event_q, event_d;
  logic [15:0] rise_en_q, rise_en_d;
  logic [15:0] fall_en_q, fall_en_d;
  logic [31:0] data_q, data_d;
  logic        ack_q, ack_d;
  logic        interrupt_q, interrupt_d;
`ifdef INPUT_EVENT_COUNT_EN
  logic [31:0] evcnt_q, evcnt_d;
`endif

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_bit
    wb_input_debounce_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_BITS       (CNT_BITS)
    ) u_bit (
      .wbs_clk_i(wbs_clk_i),
      .rst      (rst),
      .raw_i    (raw_in[i]),
      .clean_o  (clean_s[i]),
      .rise_o   (rise_s[i]),
      .fall_o   (fall_s[i])
    );
  end

  assign addr_s = wb.wbs_addr_i;

  // Bus decode, event set/clear and register next-state
  always_comb begin
    access_s = wb.wbs_cs_i & ~ack_q;
    wr_s     = access_s & wb.wbs_we_i;
    lane_s   = lane_mask(wb.wbs_sel_i);

    set_s                 = 32'h0;
    set_s[IN_WIDTH-1:0]   = rise_s & rise_en_q[IN_WIDTH-1:0];
    set_s[16 +: IN_WIDTH] = fall_s & fall_en_q[IN_WIDTH-1:0];

    case (addr_s)
      AW'(REG_STATE):   rdata_s = {{(32 - IN_WIDTH){1'b0}}, clean_s};
      AW'(REG_EVENT):   rdata_s = event_q;
      AW'(REG_RISE_EN): rdata_s = {16'h0, rise_en_q};
      AW'(REG_FALL_EN): rdata_s = {16'h0, fall_en_q};
`ifdef INPUT_EVENT_COUNT_EN
      AW'(REG_EVCNT):   rdata_s = evcnt_q;
`endif
      default:          rdata_s = 32'h0;
    endcase

    // A set arriving with a W1C on the same bit survives the clear
    if (wr_s && (addr_s == AW'(REG_EVENT))) begin
      event_d = (event_q & ~(wb.wbs_data_i & lane_s)) | set_s;
    end else begin
      event_d = event_q | set_s;
    end

    if (wr_s && (addr_s == AW'(REG_RISE_EN))) begin
      rise_en_d = (rise_en_q & ~lane_s[15:0]) | (wb.wbs_data_i[15:0] & lane_s[15:0]);
    end else begin
      rise_en_d = rise_en_q;
    end

    if (wr_s && (addr_s == AW'(REG_FALL_EN))) begin
      fall_en_d = (fall_en_q & ~lane_s[15:0]) | (wb.wbs_data_i[15:0] & lane_s[15:0]);
    end else begin
      fall_en_d = fall_en_q;
    end

    ack_d = access_s;
    if (access_s) begin
      data_d = rdata_s;
    end else begin
      data_d = 32'h0;
    end

    interrupt_d = |event_q;
  end

  // Register file and bus output flops
  always_ff @(posedge wbs_clk_i) begin
    if (rst) begin
      event_q     <= 32'h0;
      rise_en_q   <= 16'h0;
      fall_en_q   <= 16'h0;
      data_q      <= 32'h0;
      ack_q       <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      event_q     <= event_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      data_q      <= data_d;
      ack_q       <= ack_d;
      interrupt_q <= interrupt_d;
    end
  end

`ifdef INPUT_EVENT_COUNT_EN
  // Count cycles that newly set an event bit; a write restarts from this cycle
  always_comb begin
    if (wr_s && (addr_s == AW'(REG_EVCNT))) begin
      evcnt_d = {31'h0, |(set_s & ~event_q)};
    end else begin
      evcnt_d = evcnt_q + {31'h0, |(set_s & ~event_q)};
    end
  end

  // Event counter register
  always_ff @(posedge wbs_clk_i) begin
    if (rst) begin
      evcnt_q <= 32'h0;
    end else begin
      evcnt_q <= evcnt_d;
    end
  end
`endif

  assign clean_out     = clean_s;
  assign wb.wbs_data_o = data_q;
  assign wb.wbs_ack_o  = ack_q;
  assign interrupt     = interrupt_q;

endmodule
